// File: rtl/mesh_pkg.sv
// Shared definitions for the mesh contour scheduler: frame geometry, algorithm codes,
// scheduler states and mask helpers.
package mesh_pkg;

    localparam int W    = 26;
    localparam int H    = 18;
    localparam int NPIX = W * H;

    localparam logic [1:0] ALGO_PIXEL  = 2'b00;
    localparam logic [1:0] ALGO_RDBF   = 2'b01;
    localparam logic [1:0] ALGO_VERTEX = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_HOLD
    } sched_state_e;

    // An empty mask means "run everything".
    function automatic logic [2:0] effective_mask(input logic [2:0] m);
        return (m == 3'b000) ? 3'b111 : m;
    endfunction

    function automatic logic [1:0] lowest_algo(input logic [2:0] m);
        if (m[0]) return ALGO_PIXEL;
        if (m[1]) return ALGO_RDBF;
        return ALGO_VERTEX;
    endfunction

    function automatic logic [1:0] highest_algo(input logic [2:0] m);
        if (m[2]) return ALGO_VERTEX;
        if (m[1]) return ALGO_RDBF;
        return ALGO_PIXEL;
    endfunction

    function automatic logic [2:0] algo_bit(input logic [1:0] a);
        return 3'(3'b001 << a);
    endfunction

endpackage

// File: rtl/mesh_conv_detect.sv
// Convergence/timeout detector: tracks RUN cycles and consecutive unchanged-contour
// cycles, flagging convergence or budget expiry combinationally for the current cycle.
module mesh_conv_detect
    import mesh_pkg::*;
#(
    parameter int MIN_CYCLES    = 4,
    parameter int STABLE_CYCLES = 2,
    parameter int MAX_CYCLES    = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clear,
    input  logic            run,
    input  logic [NPIX-1:0] contour,
    output logic            converged,
    output logic            timeout
);

    localparam int CW = $clog2(MAX_CYCLES) + 1;

    logic [CW-1:0]   cnt_q, cnt_d;
    logic [CW-1:0]   stable_q, stable_d;
    logic [NPIX-1:0] prev_q;
    logic            match;
    logic            checking;

    // Convergence is declared in the cycle that supplies the final matching sample,
    // so the capture happens on the same edge.
    always_comb begin
        match     = (contour == prev_q);
        checking  = run && (cnt_q >= CW'(MIN_CYCLES));
        converged = checking && match && ((stable_q + 1'b1) >= CW'(STABLE_CYCLES));
        timeout   = run && (cnt_q == CW'(MAX_CYCLES - 1));
        cnt_d     = cnt_q;
        stable_d  = stable_q;
        if (clear) begin
            cnt_d    = '0;
            stable_d = '0;
        end else if (run) begin
            if (cnt_q != CW'(MAX_CYCLES - 1)) begin
                cnt_d = cnt_q + 1'b1;
            end
            if (checking) begin
                if (!match) begin
                    stable_d = '0;
                end else if (stable_q < CW'(STABLE_CYCLES)) begin
                    stable_d = stable_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            stable_q <= '0;
            prev_q   <= '0;
        end else begin
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
            prev_q   <= contour;
        end
    end

endmodule

// File: rtl/mesh_algo_scheduler.sv
// Frame-level scheduler for the 26x18 two-bit contour mesh: runs each enabled
// algorithm in ascending order and offers every captured contour on a valid/ready port.
module mesh_algo_scheduler
    import mesh_pkg::*;
#(
    parameter int MIN_CYCLES    = 4,
    parameter int STABLE_CYCLES = 2,
    parameter int MAX_CYCLES    = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [2*NPIX-1:0] frame_in,
    input  logic [2:0]        frame_mask,
    input  logic              frame_valid,
    output logic              frame_ready,
    output logic [2*NPIX-1:0] mesh_inp,
    output logic              mesh_high,
    output logic [1:0]        mesh_algo,
    input  logic [NPIX-1:0]   mesh_contour,
    output logic [NPIX-1:0]   res_contour,
    output logic [1:0]        res_algo,
    output logic              res_timeout,
    output logic              res_last,
    output logic              res_valid,
    input  logic              res_ready
);

    sched_state_e      state_q, state_d;
    logic [2*NPIX-1:0] inp_q, inp_d;
    logic [1:0]        algo_q, algo_d;
    logic [2:0]        pend_q, pend_d;
    logic [NPIX-1:0]   rcont_q, rcont_d;
    logic [1:0]        ralgo_q, ralgo_d;
    logic              rtmo_q, rtmo_d;
    logic [2:0]        remain;
    logic              converged;
    logic              timeout;
    logic              det_run;

    assign det_run = (state_q == S_RUN);

    mesh_conv_detect #(
        .MIN_CYCLES   (MIN_CYCLES),
        .STABLE_CYCLES(STABLE_CYCLES),
        .MAX_CYCLES   (MAX_CYCLES)
    ) u_detect (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (!det_run),
        .run      (det_run),
        .contour  (mesh_contour),
        .converged(converged),
        .timeout  (timeout)
    );

    always_comb begin
        state_d = state_q;
        inp_d   = inp_q;
        algo_d  = algo_q;
        pend_d  = pend_q;
        rcont_d = rcont_q;
        ralgo_d = ralgo_q;
        rtmo_d  = rtmo_q;
        remain  = pend_q & ~algo_bit(algo_q);

        frame_ready = (state_q == S_IDLE);
        mesh_high   = (state_q == S_RUN);
        res_valid   = (state_q == S_HOLD);
        res_last    = (state_q == S_HOLD) && (algo_q == highest_algo(pend_q));

        unique case (state_q)
            S_IDLE: begin
                if (frame_valid) begin
                    inp_d   = frame_in;
                    pend_d  = effective_mask(frame_mask);
                    algo_d  = lowest_algo(effective_mask(frame_mask));
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                state_d = S_RUN;
            end
            S_RUN: begin
                // Convergence takes priority when it lands on the last budgeted cycle.
                if (converged || timeout) begin
                    rcont_d = mesh_contour;
                    ralgo_d = algo_q;
                    rtmo_d  = !converged;
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (res_ready) begin
                    pend_d = remain;
                    if (remain != 3'b000) begin
                        algo_d  = lowest_algo(remain);
                        state_d = S_LOAD;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            inp_q   <= '0;
            algo_q  <= ALGO_PIXEL;
            pend_q  <= '0;
            rcont_q <= '0;
            ralgo_q <= '0;
            rtmo_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            inp_q   <= inp_d;
            algo_q  <= algo_d;
            pend_q  <= pend_d;
            rcont_q <= rcont_d;
            ralgo_q <= ralgo_d;
            rtmo_q  <= rtmo_d;
        end
    end

    assign mesh_inp    = inp_q;
    assign mesh_algo   = algo_q;
    assign res_contour = rcont_q;
    assign res_algo    = ralgo_q;
    assign res_timeout = rtmo_q;

endmodule

// File: tb/tb_mesh_algo_scheduler.sv
// Bench for mesh_algo_scheduler: a mesh stub whose contour settles after a chosen
// number of run cycles, a table of frame vectors, hand sequences and randomized frames.
module tb_mesh_algo_scheduler;
    import mesh_pkg::*;

    localparam int NP     = NPIX;
    localparam int MIN    = 4;
    localparam int STABLE = 2;
    localparam int MAX    = 64;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [2*NP-1:0] frame_in;
    logic [2:0]      frame_mask;
    logic            frame_valid;
    logic            frame_ready;
    logic [2*NP-1:0] mesh_inp;
    logic            mesh_high;
    logic [1:0]      mesh_algo;
    logic [NP-1:0]   mesh_contour;
    logic [NP-1:0]   res_contour;
    logic [1:0]      res_algo;
    logic            res_timeout;
    logic            res_last;
    logic            res_valid;
    logic            res_ready;

    int errors = 0;
    int checks = 0;
    int settleArr[4];
    int hiCount;

    typedef struct {
        logic [2:0] mask;
        int         settle;
        int         nRes;
        logic [5:0] algos;
        logic [2:0] tmo;
        int         firstLat;
    } vec_t;

    vec_t vecs[7];

    mesh_algo_scheduler #(
        .MIN_CYCLES(MIN), .STABLE_CYCLES(STABLE), .MAX_CYCLES(MAX)
    ) dut (
        .clk(clk), .rst_n(rst_n), .frame_in(frame_in), .frame_mask(frame_mask),
        .frame_valid(frame_valid), .frame_ready(frame_ready), .mesh_inp(mesh_inp),
        .mesh_high(mesh_high), .mesh_algo(mesh_algo), .mesh_contour(mesh_contour),
        .res_contour(res_contour), .res_algo(res_algo), .res_timeout(res_timeout),
        .res_last(res_last), .res_valid(res_valid), .res_ready(res_ready)
    );

    always #5 clk = ~clk;

    // Contour varies every run cycle before the settle point, then freezes.
    function automatic logic [NP-1:0] contourFn(input logic [2*NP-1:0] fr, input logic [1:0] algo,
                                                input int k, input int s);
        logic [NP-1:0] c;
        c = fr[NP-1:0] ^ fr[2*NP-1:NP] ^ {NP{algo[0]}};
        c[NP-1 -: 8] = c[NP-1 -: 8] ^ {6'd0, algo};
        if (k < s) c[7:0] = c[7:0] ^ 8'(k + 1);
        return c;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) hiCount <= 0;
        else if (mesh_high) hiCount <= hiCount + 1;
        else hiCount <= 0;
    end

    always_comb mesh_contour = contourFn(mesh_inp, mesh_algo, hiCount, settleArr[mesh_algo]);

    task automatic checkOutput(input string name, input logic [NP-1:0] act, input logic [NP-1:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, want);
        end
    endtask

    task automatic applyStimulus(input logic [2:0] mask, input logic [2*NP-1:0] fr);
        frame_in    = fr;
        frame_mask  = mask;
        frame_valid = 1'b1;
    endtask

    task automatic runFrame(input logic [2:0] mask, input int holdMode, output int nRes,
                            output logic [5:0] algosSeen, output logic [2:0] tmoSeen, output int firstLat);
        logic [2*NP-1:0] fr;
        logic [2:0]      eff;
        logic [NP-1:0]   snapC;
        logic [1:0]      snapA;
        int nExp, lastAlgo, c, w, st;
        int expAlgo[3];
        int expK[3];
        bit expTmo[3];
        bit seen;
        nRes = 0; algosSeen = '0; tmoSeen = '0; firstLat = -1; nExp = 0; lastAlgo = 0;
        for (int i = 0; i < 2*NP; i++) fr[i] = 1'($urandom_range(0, 1));
        eff = (mask == 3'b000) ? 3'b111 : mask;
        for (int a = 0; a < 3; a++) begin
            if (eff[a]) begin
                st = (settleArr[a] + 1 > MIN) ? settleArr[a] + 1 : MIN;
                expAlgo[nExp] = a;
                expK[nExp]    = st + STABLE - 1;
                expTmo[nExp]  = expK[nExp] > MAX - 1;
                if (expTmo[nExp]) expK[nExp] = MAX - 1;
                lastAlgo = a;
                nExp++;
            end
        end
        @(negedge clk);
        applyStimulus(mask, fr);
        checkOutput("accept_ready", NP'(frame_ready), NP'(1));
        for (int i = 0; i < nExp; i++) begin
            c = 0; seen = 1'b0;
            while (!seen && c < 200) begin
                @(negedge clk);
                c++;
                frame_valid = 1'b0;
                seen = res_valid;
            end
            if (!seen) begin
                checks++; errors++;
                $display("[TB] FAIL result_wait: no res_valid within %0d cycles, want algo %0d", c, expAlgo[i]);
                return;
            end
            nRes++;
            algosSeen[2*i +: 2] = res_algo;
            tmoSeen[i] = res_timeout;
            if (i == 0) firstLat = c;
            checkOutput("latency", NP'(c), NP'(expK[i] + 3));
            checkOutput("res_algo", NP'(res_algo), NP'(expAlgo[i]));
            checkOutput("res_contour", res_contour, contourFn(fr, 2'(expAlgo[i]), expK[i], settleArr[expAlgo[i]]));
            checkOutput("res_timeout", NP'(res_timeout), NP'(expTmo[i]));
            checkOutput("res_last", NP'(res_last), NP'(expAlgo[i] == lastAlgo));
            checkOutput("busy_not_ready", NP'(frame_ready), NP'(0));
            w = (holdMode < 0) ? int'($urandom_range(0, 3)) : holdMode;
            if (w > 0) begin
                snapC = res_contour; snapA = res_algo;
                res_ready = 1'b0;
                repeat (w) begin
                    @(negedge clk);
                    checkOutput("hold_contour", res_contour, snapC);
                    checkOutput("hold_algo", NP'(res_algo), NP'(snapA));
                    checkOutput("hold_valid", NP'(res_valid), NP'(1));
                    checkOutput("hold_mesh_idle", NP'(mesh_high), NP'(0));
                    checkOutput("hold_not_ready", NP'(frame_ready), NP'(0));
                    frame_in    = ~fr;
                    frame_valid = ~frame_valid;
                end
                res_ready   = 1'b1;
                frame_valid = 1'b0;
            end
            @(posedge clk);
        end
        @(negedge clk);
        checkOutput("idle_ready", NP'(frame_ready), NP'(1));
        checkOutput("no_extra_valid", NP'(res_valid), NP'(0));
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int nRes, firstLat, mode;
        logic [5:0] algos;
        logic [2:0] tmo;

        vecs[0] = '{3'b010, 3,    1, 6'b000001, 3'b000, 8};
        vecs[1] = '{3'b111, 0,    3, 6'b100100, 3'b000, 8};
        vecs[2] = '{3'b000, 3,    3, 6'b100100, 3'b000, 8};
        vecs[3] = '{3'b101, 1000, 2, 6'b001000, 3'b011, 66};
        vecs[4] = '{3'b100, 10,   1, 6'b000010, 3'b000, 15};
        vecs[5] = '{3'b001, 61,   1, 6'b000000, 3'b000, 66};
        vecs[6] = '{3'b011, 62,   2, 6'b000100, 3'b011, 66};

        for (int a = 0; a < 4; a++) settleArr[a] = 3;
        rst_n = 1'b0; res_ready = 1'b1; frame_valid = 1'b0; frame_in = '0; frame_mask = '0;
        #12;
        checkOutput("rst_frame_ready", NP'(frame_ready), NP'(1));
        checkOutput("rst_mesh_high", NP'(mesh_high), NP'(0));
        checkOutput("rst_res_valid", NP'(res_valid), NP'(0));
        checkOutput("rst_mesh_inp", mesh_inp[NP-1:0], '0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int v = 0; v < 7; v++) begin
            for (int a = 0; a < 4; a++) settleArr[a] = vecs[v].settle;
            runFrame(vecs[v].mask, 0, nRes, algos, tmo, firstLat);
            checkOutput("vec_nres", NP'(nRes), NP'(vecs[v].nRes));
            checkOutput("vec_algos", NP'(algos), NP'(vecs[v].algos));
            checkOutput("vec_tmo", NP'(tmo), NP'(vecs[v].tmo));
            checkOutput("vec_first_lat", NP'(firstLat), NP'(vecs[v].firstLat));
        end

        // Long back-pressure with ignored frame offers.
        for (int a = 0; a < 4; a++) settleArr[a] = 3;
        runFrame(3'b010, 20, nRes, algos, tmo, firstLat);
        checkOutput("bp_nres", NP'(nRes), NP'(1));

        // Asynchronous reset while the first algorithm is running at cnt=5.
        for (int a = 0; a < 4; a++) settleArr[a] = 1000;
        @(negedge clk);
        applyStimulus(3'b101, {(2*NP/4){4'b1011}});
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            frame_valid = 1'b0;
        end
        checkOutput("mid_run_high", NP'(mesh_high), NP'(1));
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_frame_ready", NP'(frame_ready), NP'(1));
        checkOutput("async_mesh_high", NP'(mesh_high), NP'(0));
        checkOutput("async_mesh_algo", NP'(mesh_algo), NP'(0));
        checkOutput("async_mesh_inp", mesh_inp[NP-1:0], '0);
        checkOutput("async_res_contour", res_contour, '0);
        checkOutput("async_res_flags", NP'({res_valid, res_last, res_timeout, res_algo}), NP'(0));
        @(negedge clk);
        rst_n = 1'b1;
        for (int a = 0; a < 4; a++) settleArr[a] = 3;
        runFrame(3'b101, 0, nRes, algos, tmo, firstLat);
        checkOutput("post_reset_first_algo", NP'(algos[1:0]), NP'(0));
        checkOutput("post_reset_nres", NP'(nRes), NP'(2));

        // Randomized frames against the model inside runFrame.
        for (int t = 0; t < 8; t++) begin
            for (int a = 0; a < 4; a++) begin
                mode = $urandom_range(0, 5);
                if (mode <= 3) settleArr[a] = $urandom_range(0, 12);
                else if (mode == 4) settleArr[a] = 1000;
                else settleArr[a] = $urandom_range(58, 63);
            end
            runFrame(3'($urandom_range(0, 7)), -1, nRes, algos, tmo, firstLat);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
